// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types and defaults for the fetch-stage PC sequencer
package pc_seq_pkg;
    localparam int ADDR_W_DEF = 10;
    localparam int RESET_PC_DEF = 0;
    typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;
    typedef enum logic [2:0] {SEL_SEQ, SEL_BR, SEL_CALL, SEL_RET, SEL_HOLD} pcSel_t;
endpackage

// File: rtl/return_addr_stack.sv
// return_addr_stack: LIFO of return addresses; push into a full stack and pop of an empty one are dropped
module return_addr_stack #(
    parameter int DEPTH = 4,
    parameter int W = 10
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0] ptr;
    logic [AW-1:0] topIdx;
    logic [W-1:0] mem [DEPTH];
    assign topIdx = AW'(ptr - 1'b1);
    assign full = ptr == (AW+1)'(DEPTH);
    assign empty = ptr == '0;
    assign top = mem[topIdx];
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr <= '0;
        end else if (pop && !empty) begin
            ptr <= ptr - 1'b1;
        end else if (push && !full) begin
            mem[ptr[AW-1:0]] <= din;
            ptr <= ptr + 1'b1;
        end
    end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage controller owning the PC, call/return stack and halt/resume FSM
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int IMM_W = 32,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_PC = RESET_PC_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [IMM_W-1:0]  Imediato,
    input  logic              MuxBranch,
    input  logic              Call,
    input  logic              Ret,
    input  logic              Halt,
    input  logic              Resume,
    input  logic              Stall,
    input  logic              MemReady,
    output logic [ADDR_W-1:0] PCAtual,
    output logic              FetchReq,
    output logic              Halted,
    output logic              StackOverflow,
    output logic              StackUnderflow
);
    state_t state, nextState;
    pcSel_t sel;
    logic advance, push, pop, full, empty;
    logic [ADDR_W-1:0] pcPlus1, target, top, pcNext;
    logic unusedImm;
    assign unusedImm = ^Imediato[IMM_W-1:ADDR_W];
    assign FetchReq = state == RUN;
    assign Halted = state == HALTED;
    assign advance = FetchReq && MemReady && !Stall;
    assign pcPlus1 = PCAtual + 1'b1;
    assign target = Imediato[ADDR_W-1:0];
    // Halt outranks everything and simply steps past the halt instruction
    assign sel = !advance ? SEL_HOLD : Halt ? SEL_SEQ : Ret ? SEL_RET
               : Call ? SEL_CALL : MuxBranch ? SEL_BR : SEL_SEQ;
    assign push = sel == SEL_CALL;
    assign pop = sel == SEL_RET;
    always_comb begin
        nextState = state == BOOT ? RUN
                  : (state == RUN && advance && Halt) ? HALTED
                  : (state == HALTED && Resume) ? RUN : state;
        pcNext = sel == SEL_HOLD ? PCAtual
               : sel == SEL_RET ? (empty ? pcPlus1 : top)
               : (sel == SEL_CALL || sel == SEL_BR) ? target : pcPlus1;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= BOOT;
            PCAtual <= ADDR_W'(RESET_PC);
            StackOverflow <= 1'b0;
            StackUnderflow <= 1'b0;
        end else begin
            state <= nextState;
            PCAtual <= pcNext;
            StackOverflow <= StackOverflow | (push && full);
            StackUnderflow <= StackUnderflow | (pop && empty);
        end
    end
    return_addr_stack #(.DEPTH(STACK_DEPTH), .W(ADDR_W)) ras (
        .clock(clock),
        .reset(reset),
        .push(push),
        .pop(pop),
        .din(pcPlus1),
        .top(top),
        .full(full),
        .empty(empty)
    );
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scenarios with expected outputs queued per cycle and checked after each edge
module tb_pc_sequencer;
    logic clock = 0, reset = 1;
    logic [31:0] Imediato = 0;
    logic MuxBranch = 0, Call = 0, Ret = 0, Halt = 0, Resume = 0, Stall = 0, MemReady = 1;
    logic [9:0] PCAtual;
    logic FetchReq, Halted, StackOverflow, StackUnderflow;
    int errors = 0, checks = 0;
    typedef struct {logic [9:0] pc; logic fr, hl, ov, un;} exp_t;
    exp_t sb[$];

    pc_sequencer dut (
        .clock(clock), .reset(reset), .Imediato(Imediato), .MuxBranch(MuxBranch),
        .Call(Call), .Ret(Ret), .Halt(Halt), .Resume(Resume), .Stall(Stall),
        .MemReady(MemReady), .PCAtual(PCAtual), .FetchReq(FetchReq), .Halted(Halted),
        .StackOverflow(StackOverflow), .StackUnderflow(StackUnderflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic [9:0] p, input logic f, input logic h, input logic o, input logic u);
        exp_t e;
        sb.push_back('{p, f, h, o, u});
        @(posedge clock);
        #1;
        e = sb.pop_front();
        check("pc", 32'(PCAtual), 32'(e.pc));
        check("fetchReq", 32'(FetchReq), 32'(e.fr));
        check("halted", 32'(Halted), 32'(e.hl));
        check("overflow", 32'(StackOverflow), 32'(e.ov));
        check("underflow", 32'(StackUnderflow), 32'(e.un));
        {MuxBranch, Call, Ret, Halt, Resume, Stall} = '0;
        MemReady = 1;
        Imediato = 0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        reset = 0;
        step(0, 1, 0, 0, 0);
        for (int i = 1; i <= 5; i++) step(10'(i), 1, 0, 0, 0);
        MuxBranch = 1; Imediato = 32'hFFFF_03FF;
        step(10'h3FF, 1, 0, 0, 0);
        for (int i = 0; i <= 7; i++) step(10'(i), 1, 0, 0, 0);
        Stall = 1; step(7, 1, 0, 0, 0);
        Stall = 1; step(7, 1, 0, 0, 0);
        MemReady = 0; step(7, 1, 0, 0, 0);
        MemReady = 0; step(7, 1, 0, 0, 0);
        step(8, 1, 0, 0, 0);
        step(9, 1, 0, 0, 0);
        step(10, 1, 0, 0, 0);
        Call = 1; Imediato = 40; step(40, 1, 0, 0, 0);
        Ret = 1; step(11, 1, 0, 0, 0);
        Call = 1; Imediato = 100; step(100, 1, 0, 0, 0);
        Call = 1; Imediato = 200; step(200, 1, 0, 0, 0);
        Call = 1; Imediato = 300; step(300, 1, 0, 0, 0);
        Call = 1; Imediato = 400; step(400, 1, 0, 0, 0);
        Call = 1; Imediato = 500; step(500, 1, 0, 1, 0);
        Ret = 1; step(301, 1, 0, 1, 0);
        Ret = 1; step(201, 1, 0, 1, 0);
        Ret = 1; step(101, 1, 0, 1, 0);
        Ret = 1; step(12, 1, 0, 1, 0);
        Ret = 1; step(13, 1, 0, 1, 1);
        for (int i = 14; i <= 20; i++) step(10'(i), 1, 0, 1, 1);
        Halt = 1; MuxBranch = 1; Imediato = 77; step(21, 0, 1, 1, 1);
        Call = 1; Ret = 1; MuxBranch = 1; Imediato = 5; step(21, 0, 1, 1, 1);
        Resume = 1; step(21, 1, 0, 1, 1);
        Call = 1; Imediato = 50; step(50, 1, 0, 1, 1);
        Call = 1; Ret = 1; Imediato = 60; step(22, 1, 0, 1, 1);
        Ret = 1; step(23, 1, 0, 1, 1);
        Resume = 1; Stall = 1; step(23, 1, 0, 1, 1);
        reset = 1; step(0, 0, 0, 0, 0);
        reset = 0; Resume = 1; step(0, 1, 0, 0, 0);
        Call = 1; Imediato = 10; step(10, 1, 0, 0, 0);
        Call = 1; Imediato = 20; step(20, 1, 0, 0, 0);
        Call = 1; Imediato = 30; step(30, 1, 0, 0, 0);
        Call = 1; Imediato = 40; step(40, 1, 0, 0, 0);
        Call = 1; Imediato = 50; step(50, 1, 0, 1, 0);
        reset = 1; Call = 1; Imediato = 99; step(0, 0, 0, 0, 0);
        reset = 0; step(0, 1, 0, 0, 0);
        Ret = 1; step(1, 1, 0, 0, 1);
        check("scoreboardEmpty", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
